// File: rtl/alu_reservation_station_if.sv
// Interface between dispatch/broadcast/ALU and alu_reservation_station.
// Optional build macro RS_ISSUE_BYPASS_EN is consumed by the station itself.
`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 4
`endif

interface alu_reservation_station_if #(
  parameter int DEPTH = 4,
  parameter int VAL_W = `GPR_SIZE,
  parameter int TAG_W = `ROB_IDX_SIZE
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Handshakes: a dispatch transfers on a rising edge where in_disp_valid and
  // out_disp_ready are both 1; an issue transfers on a rising edge where the
  // station has a ready entry and in_fu_ready is 1, then out_fu_start pulses.
  logic             in_flush;
  logic             in_disp_valid;
  logic             out_disp_ready;
  logic [3:0]       in_disp_op;
  logic             in_disp_a_ready;
  logic [VAL_W-1:0] in_disp_a_val;
  logic [TAG_W-1:0] in_disp_a_tag;
  logic             in_disp_b_ready;
  logic [VAL_W-1:0] in_disp_b_val;
  logic [TAG_W-1:0] in_disp_b_tag;
  logic             in_disp_nzcv_ready;
  logic [3:0]       in_disp_nzcv;
  logic [TAG_W-1:0] in_disp_nzcv_tag;
  logic             in_disp_set_nzcv;
  logic [TAG_W-1:0] in_disp_dst;
  logic             in_bcast_valid;
  logic [TAG_W-1:0] in_bcast_tag;
  logic [VAL_W-1:0] in_bcast_value;
  logic             in_bcast_set_nzcv;
  logic [3:0]       in_bcast_nzcv;
  logic             in_fu_ready;
  logic             out_fu_start;
  logic [3:0]       out_fu_op;
  logic [VAL_W-1:0] out_fu_val_a;
  logic [VAL_W-1:0] out_fu_val_b;
  logic [TAG_W-1:0] out_fu_dst_rob_index;
  logic             out_fu_set_nzcv;
  logic [3:0]       out_fu_nzcv;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_flush, in_disp_valid, in_disp_op,
    output in_disp_a_ready, in_disp_a_val, in_disp_a_tag,
    output in_disp_b_ready, in_disp_b_val, in_disp_b_tag,
    output in_disp_nzcv_ready, in_disp_nzcv, in_disp_nzcv_tag,
    output in_disp_set_nzcv, in_disp_dst,
    output in_bcast_valid, in_bcast_tag, in_bcast_value, in_bcast_set_nzcv, in_bcast_nzcv,
    output in_fu_ready,
    input  out_disp_ready, out_fu_start, out_fu_op, out_fu_val_a, out_fu_val_b,
    input  out_fu_dst_rob_index, out_fu_set_nzcv, out_fu_nzcv, out_count
  );

  modport slave (
    input  in_flush, in_disp_valid, in_disp_op,
    input  in_disp_a_ready, in_disp_a_val, in_disp_a_tag,
    input  in_disp_b_ready, in_disp_b_val, in_disp_b_tag,
    input  in_disp_nzcv_ready, in_disp_nzcv, in_disp_nzcv_tag,
    input  in_disp_set_nzcv, in_disp_dst,
    input  in_bcast_valid, in_bcast_tag, in_bcast_value, in_bcast_set_nzcv, in_bcast_nzcv,
    input  in_fu_ready,
    output out_disp_ready, out_fu_start, out_fu_op, out_fu_val_a, out_fu_val_b,
    output out_fu_dst_rob_index, out_fu_set_nzcv, out_fu_nzcv, out_count
  );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: collapsing queue with CDB wakeup and oldest-ready issue.
// Define RS_ISSUE_BYPASS_EN to let a ready dispatch go straight to the ALU when nothing stored is ready.
`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 4
`endif

module alu_reservation_station #(
  parameter int DEPTH = 4,
  parameter int VAL_W = `GPR_SIZE,
  parameter int TAG_W = `ROB_IDX_SIZE
) (
  input logic                     in_clk,
  input logic                     in_rst_n,
  alu_reservation_station_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic             valid;
    logic [3:0]       op;
    logic             a_rdy;
    logic [VAL_W-1:0] a_val;
    logic [TAG_W-1:0] a_tag;
    logic             b_rdy;
    logic [VAL_W-1:0] b_val;
    logic [TAG_W-1:0] b_tag;
    logic             f_rdy;
    logic [3:0]       f_nzcv;
    logic [TAG_W-1:0] f_tag;
    logic             set_nzcv;
    logic [TAG_W-1:0] dst;
  } entry_t;

  typedef struct packed {
    logic [3:0]       op;
    logic [VAL_W-1:0] a;
    logic [VAL_W-1:0] b;
    logic [TAG_W-1:0] dst;
    logic             set_nzcv;
    logic [3:0]       nzcv;
  } fu_t;

  function automatic fu_t to_fu(input entry_t e);
    fu_t f;
    f.op = e.op;
    f.a = e.a_val;
    f.b = e.b_val;
    f.dst = e.dst;
    f.set_nzcv = e.set_nzcv;
    f.nzcv = e.f_nzcv;
    return f;
  endfunction

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  entry_t           woken [DEPTH+1];
  entry_t           new_ent;
  fu_t              fu_q, fu_d;
  logic             start_q, start_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] sel_idx, tail;
  logic             sel_found, disp_ready, disp_acc, issue, bypass;

  // Registered entries updated with this edge's broadcast; slot DEPTH feeds the collapse.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = ent_q[i];
      if (bus.in_bcast_valid && ent_q[i].valid) begin
        if (!ent_q[i].a_rdy && ent_q[i].a_tag == bus.in_bcast_tag) begin
          woken[i].a_rdy = 1'b1;
          woken[i].a_val = bus.in_bcast_value;
        end
        if (!ent_q[i].b_rdy && ent_q[i].b_tag == bus.in_bcast_tag) begin
          woken[i].b_rdy = 1'b1;
          woken[i].b_val = bus.in_bcast_value;
        end
        if (!ent_q[i].f_rdy && bus.in_bcast_set_nzcv && ent_q[i].f_tag == bus.in_bcast_tag) begin
          woken[i].f_rdy  = 1'b1;
          woken[i].f_nzcv = bus.in_bcast_nzcv;
        end
      end
    end
    woken[DEPTH] = '0;
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!sel_found && ent_q[i].valid && ent_q[i].a_rdy && ent_q[i].b_rdy && ent_q[i].f_rdy) begin
        sel_found = 1'b1;
        sel_idx   = CNT_W'(i);
      end
    end
  end

  // Incoming micro-op, forwarding a same-edge broadcast so no wakeup is lost.
  always_comb begin
    new_ent          = '0;
    new_ent.valid    = 1'b1;
    new_ent.op       = bus.in_disp_op;
    new_ent.a_rdy    = bus.in_disp_a_ready;
    new_ent.a_val    = bus.in_disp_a_val;
    new_ent.a_tag    = bus.in_disp_a_tag;
    new_ent.b_rdy    = bus.in_disp_b_ready;
    new_ent.b_val    = bus.in_disp_b_val;
    new_ent.b_tag    = bus.in_disp_b_tag;
    new_ent.f_rdy    = bus.in_disp_nzcv_ready;
    new_ent.f_nzcv   = bus.in_disp_nzcv;
    new_ent.f_tag    = bus.in_disp_nzcv_tag;
    new_ent.set_nzcv = bus.in_disp_set_nzcv;
    new_ent.dst      = bus.in_disp_dst;
    if (bus.in_bcast_valid) begin
      if (!bus.in_disp_a_ready && bus.in_disp_a_tag == bus.in_bcast_tag) begin
        new_ent.a_rdy = 1'b1;
        new_ent.a_val = bus.in_bcast_value;
      end
      if (!bus.in_disp_b_ready && bus.in_disp_b_tag == bus.in_bcast_tag) begin
        new_ent.b_rdy = 1'b1;
        new_ent.b_val = bus.in_bcast_value;
      end
      if (!bus.in_disp_nzcv_ready && bus.in_bcast_set_nzcv && bus.in_disp_nzcv_tag == bus.in_bcast_tag) begin
        new_ent.f_rdy  = 1'b1;
        new_ent.f_nzcv = bus.in_bcast_nzcv;
      end
    end
  end

  assign disp_ready = (count_q != FULL);
  assign disp_acc   = bus.in_disp_valid && disp_ready;
  assign issue      = bus.in_fu_ready && sel_found;

`ifdef RS_ISSUE_BYPASS_EN
  // Any stored entry that is ready (or becomes ready this edge) is older and blocks the bypass.
  logic any_woken_rdy;
  always_comb begin
    any_woken_rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (woken[i].valid && woken[i].a_rdy && woken[i].b_rdy && woken[i].f_rdy) any_woken_rdy = 1'b1;
    end
  end
  assign bypass = disp_acc && bus.in_fu_ready && !any_woken_rdy &&
                  new_ent.a_rdy && new_ent.b_rdy && new_ent.f_rdy;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    ent_d   = ent_q;
    count_d = count_q;
    start_d = 1'b0;
    fu_d    = fu_q;
    tail    = count_q - CNT_W'(issue);
    if (bus.in_flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
      count_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i] = (issue && CNT_W'(i) >= sel_idx) ? woken[i+1] : woken[i];
      end
      if (disp_acc && !bypass) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CNT_W'(i) == tail) ent_d[i] = new_ent;
        end
      end
      count_d = tail + CNT_W'(disp_acc && !bypass);
      if (issue) begin
        start_d = 1'b1;
        fu_d    = to_fu(ent_q[sel_idx]);
      end else if (bypass) begin
        start_d = 1'b1;
        fu_d    = to_fu(new_ent);
      end
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q <= '0;
      start_q <= 1'b0;
      fu_q    <= '0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
      start_q <= start_d;
      fu_q    <= fu_d;
    end
  end

  assign bus.out_disp_ready       = disp_ready;
  assign bus.out_fu_start         = start_q;
  assign bus.out_fu_op            = fu_q.op;
  assign bus.out_fu_val_a         = fu_q.a;
  assign bus.out_fu_val_b         = fu_q.b;
  assign bus.out_fu_dst_rob_index = fu_q.dst;
  assign bus.out_fu_set_nzcv      = fu_q.set_nzcv;
  assign bus.out_fu_nzcv          = fu_q.nzcv;
  assign bus.out_count            = count_q;
endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Issue-side initiator for the ALU functional unit.
- Buffers dispatched ALU micro-ops whose operands (val_a, val_b, NZCV) may still be pending on ROB tags.
- Snoops the single ROB/CDB result broadcast to wake pending operands, then issues the oldest fully-ready entry to the func_units ALU input using its start/ready handshake.
- Sits between dispatch/rename and the ALU.

Parameters:
- DEPTH, 4, number of RS entries (power of two not required, >=2).
- VAL_W, `GPR_SIZE (64), operand/result width.
- TAG_W, `ROB_IDX_SIZE, ROB index width.

Ports:
- in_clk  input  1  clock.
- in_rst_n  input  1  reset; asynchronous, active-low.
- in_flush  input  1  mispredict flush: drop all entries.
- in_disp_valid  input  1  dispatch offers a micro-op.
- out_disp_ready  output  1  RS can accept (not full).
- in_disp_op  input  alu_op_t  ALU operation.
- in_disp_a_ready  input  1  val_a present.
- in_disp_a_val  input  VAL_W  value, if ready.
- in_disp_a_tag  input  TAG_W  producer ROB index, if not ready.
- in_disp_b_ready, in_disp_b_val, in_disp_b_tag  input  1/VAL_W/TAG_W  same for val_b.
- in_disp_nzcv_ready  input  1  flags present (dispatch sets 1 for ops not reading flags).
- in_disp_nzcv  input  nzcv_t  flags value.
- in_disp_nzcv_tag  input  TAG_W  flag producer ROB index.
- in_disp_set_nzcv  input  1  op writes flags.
- in_disp_dst  input  TAG_W  destination ROB index.
- in_bcast_valid  input  1  ROB/CDB result broadcast.
- in_bcast_tag  input  TAG_W  producing ROB index.
- in_bcast_value  input  VAL_W  result value.
- in_bcast_set_nzcv  input  1  broadcast carries flags.
- in_bcast_nzcv  input  nzcv_t  flags.
- in_fu_ready  input  1  ALU can accept (func_units out_rs_alu_ready).
- out_fu_start  output  1  issue pulse.
- out_fu_op  output  alu_op_t.
- out_fu_val_a, out_fu_val_b  output  VAL_W.
- out_fu_dst_rob_index  output  TAG_W.
- out_fu_set_nzcv  output  1.
- out_fu_nzcv  output  nzcv_t.
- out_count  output  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (async assert, sync deassert internally irrelevant):
  - all entries invalid; out_fu_start=0; all out_fu_* = 0; out_count=0.
  - out_disp_ready=1 once reset is released.
- Storage: collapsing queue; index 0 is oldest.
  - Entry fields: valid, op, a{rdy,val,tag}, b{rdy,val,tag}, f{rdy,nzcv,tag}, set_nzcv, dst.
- Dispatch: accepted at a rising edge when in_disp_valid & out_disp_ready.
  - out_disp_ready = (out_count != DEPTH), registered-state based.
  - No same-cycle issue credit when full.
  - Written at the lowest free slot after this edge's collapse.
- Wakeup: each edge with in_bcast_valid, every valid entry compares in_bcast_tag.
  - Matching non-ready a/b captures in_bcast_value and sets rdy.
  - Matching non-ready f captures in_bcast_nzcv only if in_bcast_set_nzcv.
- Same-edge dispatch + matching broadcast: the incoming operand is captured from the broadcast (forward); no lost wakeup.
- Select (combinational on registered state): lowest-index entry with a.rdy & b.rdy & f.rdy.
- Issue:
  - If in_fu_ready and a selected entry exists, at the edge the outputs register that entry's fields.
  - out_fu_start=1 for exactly one cycle; the entry is removed; higher entries shift down one.
  - Otherwise out_fu_start=0 and out_fu_* hold their last values.
- Latency (no optional feature):
  - dispatch ready at edge E → start visible after E+1.
  - broadcast wakeup at edge E → start visible after E+1.
- Backpressure: in_fu_ready=0 holds all entries; no issue, no loss.
- Simultaneous issue + dispatch on one edge: slot removed and new entry appended at post-collapse tail; count unchanged.
- in_flush (synchronous, highest priority):
  - all entries invalid; out_fu_start=0 that edge.
  - dispatch on the same edge is dropped.
- Async reset mid-operation: immediate return to reset state.

Optional Feature:
- Macro RS_ISSUE_BYPASS_EN.
- Defined:
  - conditions: RS holds no ready entry, in_fu_ready=1, and the dispatched op is fully ready (or made ready by same-edge broadcast).
  - effect: the op registers straight to out_fu_* at the dispatch edge (start visible after E) and is never written to storage.
- Undefined: normal one-extra-cycle path.
- Ordering still oldest-first: bypass is never taken if any stored entry is ready.

Test Plan:
- Dispatch PLUS a=5, b=7 ready, dst=3, fu_ready=1 → one-cycle start after E+1 with val_a=5, val_b=7, dst=3; out_count returns 0.
- Dispatch MINUS a pending tag 2, b=1; then bcast tag2 value 10 → start one edge after broadcast with val_a=10; no start before.
- Fill DEPTH=4 with fu_ready=0 → out_disp_ready=0, 5th dispatch ignored; raise fu_ready → issues dst in dispatch order 0,1,2,3 on consecutive cycles.
- CSEL with flags pending tag 6:
  - bcast tag6 with set_nzcv=0 → stays pending.
  - bcast tag6 set_nzcv=1 nzcv=0100 → issues with out_fu_nzcv=0100.
- Dispatch pending tag 4 on same edge as bcast tag4 value 9 → issues with val_a=9.
- Two entries stored, assert in_flush with a concurrent dispatch → out_count=0, no start afterwards; with RS_ISSUE_BYPASS_EN, empty RS + ready dispatch → start visible after dispatch edge.
